// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
// Forwarding select encodings and the hard-wired zero register index.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } hz_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t   FWD_REG = 2'b00;
    localparam fwd_sel_t   FWD_WB  = 2'b01;
    localparam fwd_sel_t   FWD_MEM = 2'b10;
    localparam logic [4:0] XZR     = 5'd31;

    function automatic logic writes_reg(input logic reg_write, input logic [4:0] rd,
                                        input logic [4:0] src);
        return reg_write && (rd != XZR) && (rd == src);
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Per-operand forwarding select for the execute stage.
// The younger EX/MEM result takes precedence over MEM/WB; X31 is never forwarded.
module forwarding_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output fwd_sel_t   sel
);

    always_comb begin
        sel = FWD_REG;
        if (writes_reg(mem_reg_write, mem_rd, src)) begin
            sel = FWD_MEM;
        end else if (writes_reg(wb_reg_write, wb_rd, src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller beside decode/execute: fill phase, load-use and flag-use stalls,
// taken-branch flushes, forwarding selects and saturating stall/flush event counters.
//
// state | meaning
// FILL  | post-reset drain, ID/EX bubbled for FILL_CYCLES cycles, hazards ignored
// RUN   | normal operation, stall/flush detection active
// FLUSH | one cycle after a taken branch, ID holds a bubble so detection is off
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FILL_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_flags,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_set_flags,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output fwd_sel_t         forwardA,
    output fwd_sel_t         forwardB,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int FW = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
    localparam logic [FW-1:0] FILL_LAST = FW'(FILL_CYCLES - 1);

    hz_state_t      state, state_nxt;
    logic [FW-1:0]  fill_cnt;
    logic           load_use, flag_use, stall, flush;

    forwarding_unit u_fwd_a (
        .src          (ex_rs1),
        .mem_rd       (mem_rd),
        .mem_reg_write(mem_reg_write),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .sel          (forwardA)
    );

    forwarding_unit u_fwd_b (
        .src          (ex_rs2),
        .mem_rd       (mem_rd),
        .mem_reg_write(mem_reg_write),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .sel          (forwardB)
    );

    assign load_use = ex_mem_read && ex_reg_write && (ex_rd != XZR) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign flag_use = id_uses_flags && ex_set_flags;

    always_comb begin
        state_nxt    = state;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        if (reset) begin
            // Reset cycle looks like fill so nothing stale enters execute.
            id_ex_bubble = 1'b1;
            state_nxt    = FILL;
        end else begin
            unique case (state)
                FILL: begin
                    id_ex_bubble = 1'b1;
                    if (fill_cnt == FILL_LAST) state_nxt = RUN;
                end
                RUN: begin
                    if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        flush        = 1'b1;
                        state_nxt    = FLUSH;
                    end else if (load_use || flag_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        stall        = 1'b1;
                    end
                end
                FLUSH: state_nxt = RUN;
                default: state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FILL;
            fill_cnt    <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == FILL) fill_cnt <= fill_cnt + FW'(1);
            if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
            if (flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule
